// File: rtl/bit_deser.sv
// bit_deser: serial-to-parallel byte assembler with a one-entry output register.
// Optional even-parity frame bit enabled by defining BIT_DESER_PARITY_EN.

// Output-side bundle: holds the assembled byte and its status flags
interface bit_deser_out_if;
    logic [7:0] data;
    logic       valid;
    logic       perr;
    logic       ovf;
endinterface

module bit_deser #(
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_bit,
    input  logic       i_bit_valid,
    input  logic       i_byte_ready,
    output logic [7:0] o_byte,
    output logic       o_byte_valid,
    output logic       o_overflow,
    output logic       o_parity_err
);
`ifdef BIT_DESER_PARITY_EN
    localparam int CW = 4;
    localparam logic [CW-1:0] LAST = 4'd8;
`else
    localparam int CW = 3;
    localparam logic [CW-1:0] LAST = 3'd7;
`endif

    logic [7:0]    sr;
    logic [7:0]    shifted;
    logic [7:0]    new_byte;
    logic [CW-1:0] cnt;
    logic          done;
    logic          data_bit;
    logic          new_perr;

    bit_deser_out_if out_if ();

    // Next shift value, frame completion and the byte/parity that a completing frame delivers
    always_comb begin
        shifted = MSB_FIRST ? {sr[6:0], i_bit} : {i_bit, sr[7:1]};
        done    = i_bit_valid && (cnt == LAST);
`ifdef BIT_DESER_PARITY_EN
        data_bit = (cnt != LAST);
        new_byte = sr;
        new_perr = ^{sr, i_bit};
`else
        data_bit = 1'b1;
        new_byte = shifted;
        new_perr = 1'b0;
`endif
    end

    // Bit collection: shift data bits in, count the frame and wrap on completion
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sr  <= '0;
            cnt <= '0;
        end else if (i_bit_valid) begin
            cnt <= done ? '0 : cnt + CW'(1);
            if (data_bit) sr <= shifted;
        end
    end

    // Output register: load on completion when empty or draining, else drop and flag overflow
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            out_if.data  <= '0;
            out_if.valid <= 1'b0;
            out_if.perr  <= 1'b0;
            out_if.ovf   <= 1'b0;
        end else if (done) begin
            if (!out_if.valid || i_byte_ready) begin
                out_if.data  <= new_byte;
                out_if.perr  <= new_perr;
                out_if.valid <= 1'b1;
            end else begin
                out_if.ovf <= 1'b1;
            end
        end else if (out_if.valid && i_byte_ready) begin
            out_if.valid <= 1'b0;
        end
    end

    assign o_byte       = out_if.data;
    assign o_byte_valid = out_if.valid;
    assign o_overflow   = out_if.ovf;
    assign o_parity_err = out_if.perr;
endmodule

// File: tb/tb_bit_deser.sv
// tb_bit_deser: randomized and directed bench for bit_deser (both bit orders), with a queue-based reference model.
module tb_bit_deser;
`ifdef BIT_DESER_PARITY_EN
    localparam int FL = 9;
`else
    localparam int FL = 8;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       bit_in = 1'b0;
    logic       bit_valid = 1'b0;
    logic       byte_ready = 1'b0;
    logic [7:0] byte_l, byte_m;
    logic       valid_l, valid_m, ovf_l, ovf_m, perr_l, perr_m;

    int n_pass = 0;
    int n_total = 0;

    logic       mq[$];
    logic [7:0] m_byte_l, m_byte_m;
    logic       m_valid, m_ovf, m_perr;

    always #5 clk = ~clk;

    bit_deser #(.MSB_FIRST(1'b0)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_bit(bit_in), .i_bit_valid(bit_valid),
        .i_byte_ready(byte_ready), .o_byte(byte_l), .o_byte_valid(valid_l),
        .o_overflow(ovf_l), .o_parity_err(perr_l)
    );

    bit_deser #(.MSB_FIRST(1'b1)) dut_m (
        .i_clk(clk), .i_rst_n(rst_n), .i_bit(bit_in), .i_bit_valid(bit_valid),
        .i_byte_ready(byte_ready), .o_byte(byte_m), .o_byte_valid(valid_m),
        .o_overflow(ovf_m), .o_parity_err(perr_m)
    );

    function automatic void model_step(input logic v, input logic b, input logic r);
        logic       done;
        logic [7:0] bl, bm;
        logic       p;
        done = 1'b0; bl = 8'h00; bm = 8'h00; p = 1'b0;
        if (v) begin
            mq.push_back(b);
            if (mq.size() == FL) begin
                done = 1'b1;
                for (int i = 0; i < 8; i++) begin
                    bl = bl + (8'(mq[i]) << i);
                    bm = bm + (8'(mq[i]) << (7 - i));
                end
                foreach (mq[i]) p = p ^ mq[i];
                mq.delete();
            end
        end
`ifndef BIT_DESER_PARITY_EN
        p = 1'b0;
`endif
        if (done) begin
            if (!m_valid || r) begin
                m_byte_l = bl; m_byte_m = bm; m_perr = p; m_valid = 1'b1;
            end else begin
                m_ovf = 1'b1;
            end
        end else if (m_valid && r) begin
            m_valid = 1'b0;
        end
    endfunction

    task automatic tick(input logic v, input logic b, input logic r);
        @(negedge clk);
        bit_in = b; bit_valid = v; byte_ready = r;
        model_step(v, b, r);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; bit_valid = 1'b0; byte_ready = 1'b0; bit_in = 1'b0;
        mq.delete();
        m_byte_l = 8'h00; m_byte_m = 8'h00; m_valid = 1'b0; m_ovf = 1'b0; m_perr = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] v, input logic r, input logic lr, input logic flip);
        logic [8:0] fr;
        fr = {(^v) ^ flip, v};
        for (int i = 0; i < FL; i++) tick(1'b1, fr[i], (i == FL - 1) ? lr : r);
    endtask

    task automatic test_reset();
        do_reset();
        n_total++; if (byte_l !== 8'h00) $display("FAIL reset_byte: got %h want 00", byte_l); else n_pass++;
        n_total++; if (valid_l !== 1'b0) $display("FAIL reset_valid: got %b want 0", valid_l); else n_pass++;
        n_total++; if (ovf_l !== 1'b0) $display("FAIL reset_ovf: got %b want 0", ovf_l); else n_pass++;
        n_total++; if (perr_l !== 1'b0) $display("FAIL reset_perr: got %b want 0", perr_l); else n_pass++;
        n_total++; if (byte_m !== 8'h00 || valid_m !== 1'b0) $display("FAIL reset_msb: got %h/%b want 00/0", byte_m, valid_m); else n_pass++;
    endtask

    task automatic test_bit_order();
        do_reset();
        for (int i = 0; i < FL - 1; i++) tick(1'b1, (i == 0 || i == 2), 1'b1);
        n_total++; if (valid_l !== 1'b0) $display("FAIL order_early_valid: got %b want 0", valid_l); else n_pass++;
        tick(1'b1, 1'b0, 1'b1);
        n_total++; if (byte_l !== 8'h05) $display("FAIL order_lsb_byte: got %h want 05", byte_l); else n_pass++;
        n_total++; if (byte_m !== 8'hA0) $display("FAIL order_msb_byte: got %h want a0", byte_m); else n_pass++;
        n_total++; if (valid_l !== 1'b1 || valid_m !== 1'b1) $display("FAIL order_valid: got %b%b want 11", valid_l, valid_m); else n_pass++;
        tick(1'b0, 1'b0, 1'b1);
        n_total++; if (valid_l !== 1'b0) $display("FAIL order_one_cycle: got %b want 0", valid_l); else n_pass++;
    endtask

    task automatic test_overflow();
        do_reset();
        send_byte(8'h05, 1'b0, 1'b0, 1'b0);
        n_total++; if (ovf_l !== 1'b0) $display("FAIL ovf_early: got %b want 0", ovf_l); else n_pass++;
        send_byte(8'hFF, 1'b0, 1'b0, 1'b0);
        n_total++; if (byte_l !== 8'h05 || byte_m !== 8'hA0) $display("FAIL ovf_held: got %h/%h want 05/a0", byte_l, byte_m); else n_pass++;
        n_total++; if (ovf_l !== 1'b1 || ovf_m !== 1'b1) $display("FAIL ovf_set: got %b%b want 11", ovf_l, ovf_m); else n_pass++;
        n_total++; if (valid_l !== 1'b1) $display("FAIL ovf_valid: got %b want 1", valid_l); else n_pass++;
        tick(1'b0, 1'b0, 1'b1);
        n_total++; if (valid_l !== 1'b0) $display("FAIL ovf_drain: got %b want 0", valid_l); else n_pass++;
        repeat (3) tick(1'b0, 1'b0, 1'b1);
        n_total++; if (ovf_l !== 1'b1) $display("FAIL ovf_sticky: got %b want 1", ovf_l); else n_pass++;
    endtask

    task automatic test_back_to_back();
        do_reset();
        send_byte(8'h11, 1'b0, 1'b0, 1'b0);
        n_total++; if (byte_l !== 8'h11 || valid_l !== 1'b1) $display("FAIL b2b_first: got %h/%b want 11/1", byte_l, valid_l); else n_pass++;
        send_byte(8'h22, 1'b0, 1'b1, 1'b0);
        n_total++; if (byte_l !== 8'h22) $display("FAIL b2b_second: got %h want 22", byte_l); else n_pass++;
        n_total++; if (valid_l !== 1'b1) $display("FAIL b2b_valid: got %b want 1", valid_l); else n_pass++;
        n_total++; if (ovf_l !== 1'b0) $display("FAIL b2b_ovf: got %b want 0", ovf_l); else n_pass++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        send_byte(8'h11, 1'b0, 1'b0, 1'b0);
        repeat (5) tick(1'b1, 1'b1, 1'b0);
        rst_n = 1'b0;
        #1;
        n_total++; if (byte_l !== 8'h00 || valid_l !== 1'b0) $display("FAIL mid_async: got %h/%b want 00/0", byte_l, valid_l); else n_pass++;
        do_reset();
        send_byte(8'h35, 1'b1, 1'b1, 1'b0);
        n_total++; if (byte_l !== 8'h35 || valid_l !== 1'b1) $display("FAIL mid_clean_lsb: got %h/%b want 35/1", byte_l, valid_l); else n_pass++;
        n_total++; if (byte_m !== 8'hAC) $display("FAIL mid_clean_msb: got %h want ac", byte_m); else n_pass++;
    endtask

`ifdef BIT_DESER_PARITY_EN
    task automatic test_parity();
        do_reset();
        send_byte(8'h03, 1'b1, 1'b1, 1'b0);
        n_total++; if (byte_l !== 8'h03 || perr_l !== 1'b0) $display("FAIL par_good: got %h/%b want 03/0", byte_l, perr_l); else n_pass++;
        send_byte(8'h03, 1'b1, 1'b1, 1'b1);
        n_total++; if (byte_l !== 8'h03 || perr_l !== 1'b1) $display("FAIL par_bad: got %h/%b want 03/1", byte_l, perr_l); else n_pass++;
    endtask
`endif

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 800; c++) begin
            tick(($urandom_range(0, 9) < 7), 1'($urandom), 1'($urandom));
            n_total++; if (valid_l !== m_valid || valid_m !== m_valid) $display("FAIL rnd_valid c=%0d: got %b%b want %b", c, valid_l, valid_m, m_valid); else n_pass++;
            n_total++; if (byte_l !== m_byte_l) $display("FAIL rnd_lsb c=%0d: got %h want %h", c, byte_l, m_byte_l); else n_pass++;
            n_total++; if (byte_m !== m_byte_m) $display("FAIL rnd_msb c=%0d: got %h want %h", c, byte_m, m_byte_m); else n_pass++;
            n_total++; if (ovf_l !== m_ovf || ovf_m !== m_ovf) $display("FAIL rnd_ovf c=%0d: got %b%b want %b", c, ovf_l, ovf_m, m_ovf); else n_pass++;
            n_total++; if (perr_l !== m_perr) $display("FAIL rnd_perr c=%0d: got %b want %b", c, perr_l, m_perr); else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_bit_order();
        test_overflow();
        test_back_to_back();
        test_reset_mid();
`ifdef BIT_DESER_PARITY_EN
        test_parity();
`endif
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/bit_deser.md
BIT_DESER -- requirements
Module: bit_deser

Interface
REQ-001 Parameter MSB_FIRST, default 0; 0 = first received bit lands in o_byte[0], 1 = first received bit lands in o_byte[7].
REQ-002 i_clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 i_rst_n  input  1  reset; asynchronous assert, active-low.
REQ-004 i_bit  input  1  serial data bit; sampled only when i_bit_valid=1.
REQ-005 i_bit_valid  input  1  i_bit is valid this cycle.
REQ-006 o_byte  output  8  assembled byte, driven from the packed 8-bit member of an internal interface instance.
REQ-007 o_byte_valid  output  1  o_byte holds an unconsumed byte.
REQ-008 i_byte_ready  input  1  downstream accepts o_byte this cycle.
REQ-009 o_overflow  output  1  sticky; a completed byte was dropped.
REQ-010 o_parity_err  output  1  parity flag for the byte on o_byte.

Function
REQ-011 Bit accepted at a rising edge iff i_bit_valid=1; no ready/backpressure on the bit side.
REQ-012 Shift register plus 3-bit (4-bit with parity) counter collects bits; counter wraps to 0 when a frame completes.
REQ-013 Frame complete = 8th data bit accepted (9th bit when parity compiled in).
REQ-014 On frame complete at edge N: o_byte/o_byte_valid/o_parity_err load at edge N; visible in cycle N+1; latency 1 edge from last bit.
REQ-015 Transfer occurs at an edge where o_byte_valid=1 and i_byte_ready=1.
REQ-016 Transfer with no simultaneous frame complete: o_byte_valid clears at that edge.
REQ-017 Transfer and frame complete at the same edge: new byte loads, o_byte_valid stays 1, no bubble.
REQ-018 o_byte, o_parity_err stable while o_byte_valid=1 and i_byte_ready=0.
REQ-019 Frame complete while o_byte_valid=1 and i_byte_ready=0: new byte dropped, held byte unchanged, o_overflow set; collection continues with next frame.
REQ-020 o_overflow stays 1 until reset.
REQ-021 i_byte_ready ignored while o_byte_valid=0.
REQ-022 Output register state: EMPTY (o_byte_valid=0) / FULL (o_byte_valid=1); EMPTY->FULL on frame complete; FULL->EMPTY on transfer without frame complete; otherwise hold.

Reset
REQ-023 i_rst_n=0 asynchronously forces o_byte=8'h00, o_byte_valid=0, o_overflow=0, o_parity_err=0, counter=0, shift register=0.
REQ-024 Reset mid-frame discards partial bits; first bit accepted after release starts a new frame.
REQ-025 Reset release synchronous to i_clk; first bit sampled at the first rising edge with i_rst_n=1.

Configuration
REQ-026 Macro BIT_DESER_PARITY_EN defined: frame = 8 data bits then 1 even-parity bit; o_parity_err = XOR of all 9 bits, loaded with o_byte.
REQ-027 Macro undefined: frame = 8 bits; o_parity_err port present, constant 0.

Verification
REQ-028 MSB_FIRST=0, no parity: bits 1,0,1,0,0,0,0,0 on consecutive cycles, i_byte_ready=1 -> o_byte=8'h05, o_byte_valid=1 for exactly one cycle, starting the cycle after the 8th bit.
REQ-029 MSB_FIRST=1: same bit sequence -> o_byte=8'hA0.
REQ-030 i_byte_ready=0; send 8'h05 then 8'hFF -> o_byte holds 8'h05, o_overflow=1 after 16th bit; raise ready -> 8'h05 transferred, o_byte_valid=0.
REQ-031 Back-to-back bytes 8'h11, 8'h22, i_byte_ready asserted at the edge completing 8'h22 -> o_byte_valid stays 1, o_byte changes 8'h11 -> 8'h22.
REQ-032 Assert i_rst_n=0 between edges after 5 bits -> outputs zero immediately; next 8 bits produce a clean byte with no remnant bits.
REQ-033 BIT_DESER_PARITY_EN: data 8'h03 with parity bit 0 -> o_parity_err=0; parity bit 1 -> o_parity_err=1.
